// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared types and constants for the convolve-accumulate scheduler
//
// Purpose: scheduler FSM state encoding and SRAM read latency.
// Ports: none (package).
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_W,
    STREAM,
    DRAIN,
    NEXT,
    DONE
  } state_e;

  // Weight/feature SRAMs return data one cycle after the address is issued,
  // so the valid strobes are the issue strobes delayed by this many cycles.
  localparam int SRAM_RD_LAT = 1;

endpackage

// File: rtl/conv_accum_sched_if.sv
// rtl/conv_accum_sched_if.sv - job, SRAM address and datapath control bundle for conv_accum_sched
//
// Purpose: groups the scheduler's job request, SRAM read addresses, datapath
// strobes and status into one bundle.
// Modports:
//   master - scheduler side: receives job config and wr_en_conv, drives the rest
//   slave  - job issuer / datapath side
interface conv_accum_sched_if #(
  parameter int MaxRowWidth = 9,
  parameter int MaxColWidth = 9,
  parameter int GroupWidth  = 8,
  parameter int AddrWidth   = 16
) ();

  logic                   start;
  logic [MaxRowWidth-1:0] row_cfg;
  logic [MaxColWidth-1:0] col_cfg;
  logic [GroupWidth-1:0]  grp_cfg;
  logic [AddrWidth-1:0]   wt_rd_addr;
  logic [AddrWidth-1:0]   fm_rd_addr;
  logic                   weight_valid;
  logic                   data_valid;
  logic                   conv_first;
  logic                   conv_rst;
  logic [MaxRowWidth-1:0] row_out;
  logic [MaxColWidth-1:0] col_out;
  logic                   wr_en_conv;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    input  start, row_cfg, col_cfg, grp_cfg, wr_en_conv,
    output wt_rd_addr, fm_rd_addr, weight_valid, data_valid, conv_first,
           conv_rst, row_out, col_out, busy, done, error
  );

  modport slave (
    output start, row_cfg, col_cfg, grp_cfg, wr_en_conv,
    input  wt_rd_addr, fm_rd_addr, weight_valid, data_valid, conv_first,
           conv_rst, row_out, col_out, busy, done, error
  );

endinterface

// File: rtl/sched_addr_gen.sv
// rtl/sched_addr_gen.sv - group base-address accumulators and beat counter
//
// Purpose: produces weight and feature SRAM read addresses as base + beat.
// Bases advance by KernelSize and row*col per group, so no multiplier is needed.
// Ports:
//   Clk, Rst  - clock, synchronous active-high reset
//   job_clr   - new job accepted: bases and beat to 0
//   grp_adv   - advance both bases to the next group
//   beat_clr  - restart the beat counter
//   beat_inc  - count one issued beat
//   fm_step   - row*col of the current job (modulo 2^AddrWidth)
//   wt_addr   - weight address, fm_addr - feature address, beat - beat index
module sched_addr_gen #(
  parameter int KernelSize = 9,
  parameter int AddrWidth  = 16,
  parameter int BeatWidth  = 18
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 job_clr,
  input  logic                 grp_adv,
  input  logic                 beat_clr,
  input  logic                 beat_inc,
  input  logic [AddrWidth-1:0] fm_step,
  output logic [AddrWidth-1:0] wt_addr,
  output logic [AddrWidth-1:0] fm_addr,
  output logic [BeatWidth-1:0] beat
);

  logic [AddrWidth-1:0] wt_base_q, wt_base_d;
  logic [AddrWidth-1:0] fm_base_q, fm_base_d;
  logic [BeatWidth-1:0] beat_q, beat_d;

  always_comb begin
    wt_base_d = wt_base_q;
    fm_base_d = fm_base_q;
    beat_d    = beat_q;
    if (job_clr) begin
      wt_base_d = '0;
      fm_base_d = '0;
    end else if (grp_adv) begin
      wt_base_d = wt_base_q + AddrWidth'(KernelSize);
      fm_base_d = fm_base_q + fm_step;
    end
    if (job_clr || beat_clr) begin
      beat_d = '0;
    end else if (beat_inc) begin
      beat_d = beat_q + BeatWidth'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wt_base_q <= '0;
      fm_base_q <= '0;
      beat_q    <= '0;
    end else begin
      wt_base_q <= wt_base_d;
      fm_base_q <= fm_base_d;
      beat_q    <= beat_d;
    end
  end

  // Address arithmetic wraps naturally at AddrWidth bits.
  assign wt_addr = wt_base_q + beat_q[AddrWidth-1:0];
  assign fm_addr = fm_base_q + beat_q[AddrWidth-1:0];
  assign beat    = beat_q;

endmodule

// File: rtl/conv_accum_sched.sv
// rtl/conv_accum_sched.sv - layer job sequencer for the 4-channel convolve-accumulate datapath
//
// Purpose: for each input-channel group clears the datapath, fetches KernelSize
// weight beats, streams row*col feature beats, then waits until all expected
// partial sums are written back. Pulses done after the last group.
// Optional: CONV_SCHED_WATCHDOG_EN adds a DRAIN watchdog that sets a sticky
// error and forces DONE after TimeoutCycles DRAIN cycles.
// Ports:
//   Clk, Rst - clock, synchronous active-high reset
//   bus      - conv_accum_sched_if.master: job config in, SRAM addresses,
//              valid strobes, conv_first/conv_rst, row/col out, status out
module conv_accum_sched
  import conv_sched_pkg::*;
#(
  parameter int KernelSize    = 9,
  parameter int KernelDim     = 3,
  parameter int MaxRowWidth   = 9,
  parameter int MaxColWidth   = 9,
  parameter int GroupWidth    = 8,
  parameter int AddrWidth     = 16,
  parameter int TimeoutCycles = 1024
) (
  input  logic               Clk,
  input  logic               Rst,
  conv_accum_sched_if.master bus
);

  localparam int BW = MaxRowWidth + MaxColWidth;

  state_e                 state_q, state_d;
  logic [MaxRowWidth-1:0] row_q, row_d;
  logic [MaxColWidth-1:0] col_q, col_d;
  logic [GroupWidth-1:0]  grp_q, grp_d;
  logic [GroupWidth-1:0]  g_q, g_d;
  logic [BW-1:0]          rowcol_q, rowcol_d;
  logic [AddrWidth-1:0]   exp_q, exp_d;
  logic [AddrWidth-1:0]   wr_cnt_q, wr_cnt_d;
  logic                   wv_q, wv_d;
  logic                   dv_q, dv_d;

  logic                   accept;
  logic                   last_w;
  logic                   last_f;
  logic [BW-1:0]          out_rows, out_cols, rowcol_w;
  logic [AddrWidth-1:0]   wt_addr, fm_addr;
  logic [BW-1:0]          beat;

`ifdef CONV_SCHED_WATCHDOG_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           error_q, error_d;
`endif

  assign accept = (state_q == IDLE) && bus.start;
  assign last_w = (beat == BW'(KernelSize - 1));
  assign last_f = (beat == rowcol_q - BW'(1));

  // Output feature-map extent; only meaningful when row/col >= KernelDim.
  always_comb begin
    out_rows = BW'(bus.row_cfg) - BW'(KernelDim - 1);
    out_cols = BW'(bus.col_cfg) - BW'(KernelDim - 1);
    rowcol_w = BW'(bus.row_cfg) * BW'(bus.col_cfg);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    grp_d    = grp_q;
    g_d      = g_q;
    rowcol_d = rowcol_q;
    exp_d    = exp_q;
    wr_cnt_d = wr_cnt_q;
    wv_d     = (state_q == LOAD_W);
    dv_d     = (state_q == STREAM);
`ifdef CONV_SCHED_WATCHDOG_EN
    error_d  = error_q;
    wd_cnt_d = (state_q == DRAIN) ? wd_cnt_q + WdW'(1) : '0;
`endif

    // Write-backs can land while features are still streaming, so they are
    // counted from LOAD_W onwards rather than only in DRAIN.
    if ((state_q == LOAD_W || state_q == STREAM || state_q == DRAIN) && bus.wr_en_conv) begin
      wr_cnt_d = wr_cnt_q + AddrWidth'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          row_d    = bus.row_cfg;
          col_d    = bus.col_cfg;
          grp_d    = bus.grp_cfg;
          g_d      = '0;
          rowcol_d = rowcol_w;
          if (bus.row_cfg < MaxRowWidth'(KernelDim) || bus.col_cfg < MaxColWidth'(KernelDim)) begin
            exp_d = '0;
          end else begin
            exp_d = AddrWidth'(out_rows * out_cols);
          end
`ifdef CONV_SCHED_WATCHDOG_EN
          error_d = 1'b0;
`endif
          state_d = (bus.grp_cfg == '0) ? DONE : CLR;
        end
      end
      CLR: begin
        wr_cnt_d = '0;
        state_d  = LOAD_W;
      end
      LOAD_W: begin
        // A zero-sized feature map has no stream phase at all.
        if (last_w) state_d = (rowcol_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        if (last_f) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_cnt_q == exp_q) begin
          state_d = NEXT;
        end
`ifdef CONV_SCHED_WATCHDOG_EN
        else if (wd_cnt_q == WdW'(TimeoutCycles - 1)) begin
          error_d = 1'b1;
          state_d = DONE;
        end
`endif
      end
      NEXT: begin
        g_d     = g_q + GroupWidth'(1);
        state_d = (g_d < grp_q) ? CLR : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      grp_q    <= '0;
      g_q      <= '0;
      rowcol_q <= '0;
      exp_q    <= '0;
      wr_cnt_q <= '0;
      wv_q     <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      grp_q    <= grp_d;
      g_q      <= g_d;
      rowcol_q <= rowcol_d;
      exp_q    <= exp_d;
      wr_cnt_q <= wr_cnt_d;
      wv_q     <= wv_d;
      dv_q     <= dv_d;
    end
  end

`ifdef CONV_SCHED_WATCHDOG_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  sched_addr_gen #(
    .KernelSize (KernelSize),
    .AddrWidth  (AddrWidth),
    .BeatWidth  (BW)
  ) u_addr_gen (
    .Clk      (Clk),
    .Rst      (Rst),
    .job_clr  (accept),
    .grp_adv  (state_q == NEXT),
    .beat_clr ((state_q == CLR) || (state_q == LOAD_W && last_w)),
    .beat_inc ((state_q == LOAD_W) || (state_q == STREAM)),
    .fm_step  (rowcol_q[AddrWidth-1:0]),
    .wt_addr  (wt_addr),
    .fm_addr  (fm_addr),
    .beat     (beat)
  );

  assign bus.wt_rd_addr   = (state_q == LOAD_W) ? wt_addr : '0;
  assign bus.fm_rd_addr   = (state_q == STREAM) ? fm_addr : '0;
  assign bus.weight_valid = wv_q;
  assign bus.data_valid   = dv_q;
  assign bus.conv_rst     = (state_q == CLR);
  assign bus.conv_first   = (g_q == '0) &&
                            (state_q == CLR || state_q == LOAD_W ||
                             state_q == STREAM || state_q == DRAIN);
  assign bus.row_out      = row_q;
  assign bus.col_out      = col_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);

endmodule

// File: tb/tb_conv_accum_sched.sv
// tb/tb_conv_accum_sched.sv - scoreboard bench for conv_accum_sched
module tb_conv_accum_sched;

  typedef struct {
    logic [15:0] addr;
    logic        first;
  } beat_t;

  logic clk;
  logic rst;

  conv_accum_sched_if #(.MaxRowWidth(9), .MaxColWidth(9), .GroupWidth(8), .AddrWidth(16)) bus ();

  conv_accum_sched #(.TimeoutCycles(16)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t wq[$];
  beat_t dq[$];

  int        rst_cnt = 0;
  int        done_cnt = 0;
  int        cyc = 0;
  int        last_dv_cyc = 0;
  int        done_cyc = 0;
  int        rem = 0;
  int        exp_tb = 0;
  bit        wr_ena = 1'b1;
  logic [15:0] prev_wt = '0;
  logic [15:0] prev_fm = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"}, bus.busy, 0);
    check_eq({pfx, "_done"}, bus.done, 0);
    check_eq({pfx, "_error"}, bus.error, 0);
    check_eq({pfx, "_conv_rst"}, bus.conv_rst, 0);
    check_eq({pfx, "_conv_first"}, bus.conv_first, 0);
    check_eq({pfx, "_wv"}, bus.weight_valid, 0);
    check_eq({pfx, "_dv"}, bus.data_valid, 0);
    check_eq({pfx, "_wt_addr"}, bus.wt_rd_addr, 0);
    check_eq({pfx, "_fm_addr"}, bus.fm_rd_addr, 0);
    check_eq({pfx, "_row_out"}, bus.row_out, 0);
    check_eq({pfx, "_col_out"}, bus.col_out, 0);
  endtask

  // Expected beats of a whole job, in issue order.
  task automatic push_job(input int r, input int c, input int g);
    beat_t b;
    for (int gi = 0; gi < g; gi++) begin
      for (int k = 0; k < 9; k++) begin
        b.addr  = 16'(gi * 9 + k);
        b.first = (gi == 0);
        wq.push_back(b);
      end
      for (int k = 0; k < r * c; k++) begin
        b.addr  = 16'(gi * r * c + k);
        b.first = (gi == 0);
        dq.push_back(b);
      end
    end
  endtask

  function automatic int exp_writes(input int r, input int c);
    return (r < 3 || c < 3) ? 0 : (r - 2) * (c - 2);
  endfunction

  // Datapath model + monitor: every output sampled on the falling edge.
  initial begin
    beat_t b;
    bus.wr_en_conv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.conv_rst) begin
        rst_cnt++;
        rem = exp_tb;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.weight_valid) begin
        check_eq("wt_q_nonempty", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          b = wq.pop_front();
          check_eq("wt_addr", prev_wt, b.addr);
          check_eq("wt_first", bus.conv_first, b.first);
        end
      end
      if (bus.data_valid) begin
        last_dv_cyc = cyc;
        check_eq("fm_q_nonempty", dq.size() > 0, 1);
        if (dq.size() > 0) begin
          b = dq.pop_front();
          check_eq("fm_addr", prev_fm, b.addr);
          check_eq("fm_first", bus.conv_first, b.first);
        end
      end
      prev_wt = bus.wt_rd_addr;
      prev_fm = bus.fm_rd_addr;
      if (wr_ena && bus.data_valid && rem > 0) begin
        bus.wr_en_conv = 1'b1;
        rem--;
      end else begin
        bus.wr_en_conv = 1'b0;
      end
    end
  end

  task automatic drive_start(input int r, input int c, input int g);
    @(negedge clk);
    bus.row_cfg = 9'(r);
    bus.col_cfg = 9'(c);
    bus.grp_cfg = 8'(g);
    bus.start   = 1'b1;
  endtask

  task automatic run_job(input int r, input int c, input int g);
    int  rst0;
    int  done0;
    int  lat;
    bit  seen;
    exp_tb = exp_writes(r, c);
    push_job(r, c, g);
    rst0 = rst_cnt;
    done0 = done_cnt;
    drive_start(r, c, g);
    seen = 0;
    lat = 0;
    for (int i = 1; i <= 20000 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1;
        lat = i;
      end
    end
    check_eq("done_seen", seen, 1);
    if (g == 0) check_eq("grp0_done_latency", (lat >= 1 && lat <= 2), 1);
    @(negedge clk);
    check_eq("done_one_cycle", bus.done, 0);
    check_eq("busy_after_done", bus.busy, 0);
    #1;
    check_eq("conv_rst_pulses", rst_cnt - rst0, g);
    check_eq("done_pulses", done_cnt - done0, 1);
    check_eq("wt_q_drained", wq.size(), 0);
    check_eq("fm_q_drained", dq.size(), 0);
    check_eq("row_out", bus.row_out, r);
    check_eq("col_out", bus.col_out, c);
    check_eq("error_clear", bus.error, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    wq.delete();
    dq.delete();
    exp_tb = 0;
    rem = 0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.row_cfg = '0;
    bus.col_cfg = '0;
    bus.grp_cfg = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_job(4, 4, 1);
    run_job(5, 5, 3);
    run_job(6, 7, 0);
    run_job(2, 9, 1);

    // Reset during the feature stream of group 1, then a clean job.
    exp_tb = exp_writes(4, 4);
    push_job(4, 4, 2);
    drive_start(4, 4, 2);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.data_valid && !bus.conv_first) seen = 1;
    end
    check_eq("grp1_stream_reached", seen, 1);
    pulse_reset();
    run_job(3, 3, 1);

    // No write-backs at all: DRAIN never completes on its own.
    wr_ena = 1'b0;
    exp_tb = exp_writes(4, 4);
    push_job(4, 4, 1);
    drive_start(4, 4, 1);
`ifdef CONV_SCHED_WATCHDOG_EN
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1;
    end
    check_eq("wd_done_seen", seen, 1);
    check_eq("wd_error", bus.error, 1);
    #1;
    check_eq("wd_drain_cycles", done_cyc - last_dv_cyc, 16);
    check_eq("wd_wt_q_drained", wq.size(), 0);
    check_eq("wd_fm_q_drained", dq.size(), 0);
    wr_ena = 1'b1;
    run_job(3, 3, 1);
`else
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1;
    end
    check_eq("nowd_no_done", seen, 0);
    check_eq("nowd_busy", bus.busy, 1);
    check_eq("nowd_error", bus.error, 0);
    wr_ena = 1'b1;
    pulse_reset();
    run_job(3, 3, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
